// File: rtl/riscv_fetch_unit.sv
// Instruction-fetch front end: credit-limited request port, in-order response tracking,
// prefetch FIFO toward IF/ID, and redirect flush that drops responses still in flight.
module riscv_fetch_unit #(
    parameter int unsigned     XLEN       = 32,
    parameter int unsigned     FIFO_DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC   = '0
) (
    input  logic                          clock,
    input  logic                          reset,
    output logic                          imem_req_valid,
    input  logic                          imem_req_ready,
    output logic [XLEN-1:0]               imem_req_addr,
    input  logic                          imem_resp_valid,
    input  logic [31:0]                   imem_resp_data,
    input  logic                          redirect_valid,
    input  logic [XLEN-1:0]               redirect_pc,
    output logic                          if_valid,
    input  logic                          if_ready,
    output logic [31:0]                   if_instruction,
    output logic [XLEN-1:0]               if_pc,
    output logic [XLEN-1:0]               if_pc_plus4,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_EXT = (CW + 1)'(FIFO_DEPTH);

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] resp_pc;
    logic [CW-1:0]   live_out;
    logic [CW-1:0]   discard_cnt;
    logic [CW-1:0]   count;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [31:0]     data_mem [FIFO_DEPTH];
    logic [XLEN-1:0] pc_mem   [FIFO_DEPTH];

    logic [CW:0]     live_plus_fifo;
    logic [CW:0]     live_plus_discard;
    logic            req_fire;
    logic            resp_drop;
    logic            push;
    logic            pop;
    logic [XLEN-1:0] target_pc;
    logic            unused_low_bits;

    assign unused_low_bits   = ^redirect_pc[1:0];
    assign target_pc         = {redirect_pc[XLEN-1:2], 2'b00};
    assign live_plus_fifo    = {1'b0, live_out} + {1'b0, count};
    assign live_plus_discard = {1'b0, live_out} + {1'b0, discard_cnt};

    // Credits cover both FIFO slots and stale responses, so every accepted word has a home.
    assign imem_req_valid = !reset && !redirect_valid
                            && (live_plus_fifo < DEPTH_EXT)
                            && (live_plus_discard < DEPTH_EXT);
    assign imem_req_addr  = fetch_pc;

    assign req_fire  = imem_req_valid && imem_req_ready;
    assign resp_drop = imem_resp_valid && (discard_cnt != '0);
    assign push      = imem_resp_valid && (discard_cnt == '0) && !redirect_valid;
    assign pop       = if_valid && if_ready && !redirect_valid;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            live_out    <= '0;
            discard_cnt <= '0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else if (redirect_valid) begin
            // A response landing in the redirect cycle is already one of the in-flight ones.
            fetch_pc    <= target_pc;
            resp_pc     <= target_pc;
            live_out    <= '0;
            discard_cnt <= discard_cnt + live_out - CW'(imem_resp_valid);
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else begin
            if (req_fire)  fetch_pc    <= fetch_pc + XLEN'(4);
            if (push)      resp_pc     <= resp_pc + XLEN'(4);
            if (resp_drop) discard_cnt <= discard_cnt - CW'(1);
            if (push)      wr_ptr      <= wr_ptr + PW'(1);
            if (pop)       rd_ptr      <= rd_ptr + PW'(1);
            live_out <= live_out + CW'(req_fire) - CW'(push);
            count    <= count + CW'(push) - CW'(pop);
        end
    end

    // NOTE: FIFO storage has no reset; the pointers and count alone decide which entries are valid.
    always_ff @(posedge clock) begin
        if (push) begin
            data_mem[wr_ptr] <= imem_resp_data;
            pc_mem[wr_ptr]   <= resp_pc;
        end
    end

    assign if_valid       = (count != '0);
    assign if_instruction = if_valid ? data_mem[rd_ptr] : 32'h0;
    assign if_pc          = if_valid ? pc_mem[rd_ptr] : resp_pc;
    assign if_pc_plus4    = if_pc + XLEN'(4);
    assign fifo_level     = count;

    a_resp_has_request: assert property (@(posedge clock) disable iff (reset)
        imem_resp_valid |-> (live_out != '0 || discard_cnt != '0));
    a_no_overflow: assert property (@(posedge clock) disable iff (reset)
        (push && !pop) |-> (count < CW'(FIFO_DEPTH)));
endmodule

// File: doc/riscv_fetch_unit.md
Name: riscv_fetch_unit

Overview:
Parametrised instruction-fetch front end for the 5-stage RISC-V core. It decouples the PC from instruction memory through a valid/ready request port and supports variable memory latency with in-order responses. Fetched words are buffered in a prefetch FIFO of FIFO_DEPTH entries and handed to the IF/ID register through a valid/ready handshake. Redirect handling (branch/jump from EX) flushes the FIFO and silently discards responses that are still in flight.

Parameters:
XLEN, 32, address/PC width in bits
FIFO_DEPTH, 4, prefetch entries; power of two, >= 2; also the cap on total in-flight requests
RESET_PC, 32'h0000_0000, first fetch address after reset (bits [1:0] must be 0)

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request this cycle
imem_req_addr  out  XLEN  word-aligned fetch address
imem_resp_valid  in  1  response valid; always accepted; responses return in request order
imem_resp_data  in  32  instruction word
redirect_valid  in  1  branch/jump taken (pc_branch_sel)
redirect_pc  in  XLEN  new PC; bits [1:0] ignored (treated as 0)
if_valid  out  1  instruction available to decode
if_ready  in  1  decode accepts (low = stall)
if_instruction  out  32  head-of-FIFO instruction
if_pc  out  XLEN  PC of if_instruction
if_pc_plus4  out  XLEN  if_pc + 4, modulo 2^XLEN
fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset: the following hold asynchronously while reset is high. fetch_pc = RESET_PC, resp_pc = RESET_PC, live_out = 0, discard_cnt = 0, FIFO empty. Outputs: imem_req_valid = 0, if_valid = 0, fifo_level = 0, imem_req_addr = RESET_PC, if_pc = RESET_PC.
- Request issue:
  - imem_req_valid = !reset && !redirect_valid && (live_out + fifo_level < FIFO_DEPTH) && (live_out + discard_cnt < FIFO_DEPTH).
  - imem_req_addr = fetch_pc.
  - On handshake: fetch_pc += 4 (wraps) and live_out increments.
  - imem_req_valid must not drop, and imem_req_addr must not change, while waiting for ready, except on redirect.
- Response:
  - If discard_cnt > 0, the response is dropped and discard_cnt decrements.
  - Otherwise {imem_resp_data, resp_pc} is pushed into the FIFO, resp_pc += 4, and live_out decrements.
  - The credit rule guarantees the FIFO never overflows. An overflow or a response with no request in flight is an assertion failure.
- Output:
  - if_valid = FIFO not empty; if_instruction, if_pc and if_pc_plus4 come from the head entry.
  - Pop on if_valid && if_ready.
  - Push and pop in the same cycle are both honoured, including when the FIFO is full (the credit rule already reserved the slot).
  - Pointers wrap modulo FIFO_DEPTH.
- Latency: a request accepted in cycle N with a response in cycle N+M gives if_valid high in cycle N+M+1. There is no FIFO bypass.
- Redirect (redirect_valid high in cycle N), taking effect at the edge ending N:
  - FIFO cleared; a pop in cycle N is discarded and not counted.
  - fetch_pc and resp_pc are set to {redirect_pc[XLEN-1:2], 2'b00}.
  - discard_cnt is set to discard_cnt + live_out, minus 1 if a response arrives in cycle N (that response is dropped).
  - live_out is set to 0.
  - No request is issued in cycle N. The first request to the new PC is issued in cycle N+1 if credit allows.
  - Back-to-back redirects: the last one wins, and the discard counts accumulate correctly.
- Reset mid-operation: all state returns to reset values immediately. The memory is assumed to be reset alongside, so no stale responses are expected.
- Width rule: all PC arithmetic is unsigned modulo 2^XLEN; 32'hFFFF_FFFC + 4 = 0.

Test Plan:
1. Reset release, memory ready = 1, zero-wait (response in N+1), if_ready = 1 -> requests to 0x0, 0x4, 0x8 …; if_valid first high 2 cycles after the first request; if_pc sequence 0, 4, 8 matches the data.
2. if_ready = 0 for 10 cycles, FIFO_DEPTH = 4 -> exactly 4 requests issued; fifo_level = 4; imem_req_valid = 0. Releasing if_ready drains entries in order and issuing resumes.
3. Memory latency of 3 cycles, 2 requests in flight, then redirect_valid with redirect_pc = 0x103 -> both responses dropped; FIFO empty after the redirect; next request address 0x100; next if_pc = 0x100.
4. Redirect in the same cycle as a response and a pop -> the response is dropped; the popped entry is not delivered twice; discard_cnt = live_out - 1.
5. imem_req_ready held 0 for 5 cycles -> imem_req_valid and imem_req_addr stay stable; a redirect in that window changes imem_req_addr to the new PC one cycle later.
6. RESET_PC = 32'hFFFF_FFF8 -> fetch addresses FFFF_FFF8, FFFF_FFFC, 0000_0000; if_pc_plus4 of the second instruction = 0. Asserting reset mid-stream clears if_valid and fifo_level immediately.
